boot_mem: RTL and testbench



---
 rtl/boot_mem.sv | 234 +++++++++++++++++++++++
 tb/tb_boot_mem.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_mem.sv
// boot_mem: word-organised on-chip memory serving the rv32 core's fetch,
// load and store strobes, with an optional byte-stream boot loader.
//
// Optional feature macro: BOOT_MEM_BOOTLOAD_EN
//   defined   -> boot FSM (HDR0/HDR1/DATA/RUN) fills memory from boot_data
//                while holding the core in reset; INIT_FILE is ignored.
//   undefined -> no boot FSM; core_reset
//                releases exactly two clock edges after reset deasserts.
//
// Ports:
//   clk         clock
//   reset       asynchronous active-low reset
//   mem_addr    byte address from the core
//   mem_wdata   store data
//   mem_rd      read strobe (one-cycle pulse)
//   mem_wr      write strobe (one-cycle pulse)
//   mem_rdata   read data, valid one cycle after the read strobe, held
//   addr_err    one-cycle pulse when a core request is dropped
//   core_reset  active-high reset to the core
//   boot_data   boot byte
//   boot_valid  boot byte valid
//   boot_ready  loader accepts a byte this cycle
//   boot_done   memory image complete
module boot_mem #(
  parameter int    ADDR_WIDTH  = 32,
  parameter int    DEPTH_WORDS = 1024,
  parameter string INIT_FILE   = ""
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_wdata,
  input  logic                  mem_rd,
  input  logic                  mem_wr,
  output logic [31:0]           mem_rdata,
  output logic                  addr_err,
  output logic                  core_reset,
  input  logic [7:0]            boot_data,
  input  logic                  boot_valid,
  output logic                  boot_ready,
  output logic                  boot_done
);

  localparam int IW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem [DEPTH_WORDS];
  logic [IW-1:0] idx;
  logic          addr_ok;
  logic          core_rd;
  logic          core_wr;
  logic          core_req;
  logic          we;
  logic [IW-1:0] waddr;
  logic [31:0]   wdata;
  logic          boot_we;
  logic [IW-1:0] boot_waddr;
  logic [31:0]   boot_wdata;

  assign idx = mem_addr[IW+1:2];
  // Word aligned and no address bit set above the index range.
  assign addr_ok = (mem_addr[1:0] == 2'b00) &&
                   ((mem_addr >> (IW + 2)) == {ADDR_WIDTH{1'b0}});

  // The core is not allowed to touch memory while it is held in reset.
  assign core_rd  = mem_rd & ~core_reset;
  assign core_wr  = mem_wr & ~core_reset;
  assign core_req = core_rd | core_wr;

  // Single write port: core stores and boot writes never overlap because
  // boot writes only happen while core_reset is high.
  always_comb begin
    we    = 1'b0;
    waddr = {IW{1'b0}};
    wdata = 32'h0000_0000;
    if (core_wr && addr_ok) begin
      we    = 1'b1;
      waddr = idx;
      wdata = mem_wdata;
    end else if (boot_we) begin
      we    = 1'b1;
      waddr = boot_waddr;
      wdata = boot_wdata;
    end else begin
      we    = 1'b0;
    end
  end

  // Memory array write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read data (read-before-write) and dropped-request flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_rdata <= 32'h0000_0000;
      addr_err  <= 1'b0;
    end else begin
      addr_err <= core_req & ~addr_ok;
      if (core_rd) begin
        mem_rdata <= addr_ok ? mem[idx] : 32'h0000_0000;
      end
    end
  end

`ifdef BOOT_MEM_BOOTLOAD_EN

  typedef enum logic [1:0] {
    HDR0 = 2'd0,
    HDR1 = 2'd1,
    DATA = 2'd2,
    RUN  = 2'd3
  } boot_state_t;

  boot_state_t state;
  logic [15:0] count;
  logic [31:0] word_ptr;
  logic [1:0]  byte_cnt;
  logic [23:0] word_buf;
  logic        accept;
  logic [15:0] count_full;
  logic [31:0] word_ptr_inc;

  assign accept       = boot_valid & boot_ready;
  assign count_full   = {boot_data, count[7:0]};
  assign word_ptr_inc = word_ptr + 32'd1;

  // Fourth byte of a word completes it; words past the end are consumed
  // but dropped so the image never wraps onto low memory.
  assign boot_we    = (state == DATA) && accept && (byte_cnt == 2'd3) &&
                      (word_ptr < 32'(DEPTH_WORDS));
  assign boot_waddr = word_ptr[IW-1:0];
  assign boot_wdata = {boot_data, word_buf};

  // Boot loader FSM with registered boot_ready/core_reset/boot_done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= HDR0;
      count      <= 16'h0000;
      word_ptr   <= 32'h0000_0000;
      byte_cnt   <= 2'd0;
      word_buf   <= 24'h00_0000;
      boot_ready <= 1'b0;
      core_reset <= 1'b1;
      boot_done  <= 1'b0;
    end else begin
      case (state)
        HDR0: begin
          boot_ready <= 1'b1;
          if (accept) begin
            count[7:0] <= boot_data;
            state      <= HDR1;
          end
        end
        HDR1: begin
          boot_ready <= 1'b1;
          if (accept) begin
            count <= count_full;
            if (count_full == 16'h0000) begin
              state      <= RUN;
              boot_ready <= 1'b0;
              core_reset <= 1'b0;
              boot_done  <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          boot_ready <= 1'b1;
          if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              word_ptr <= word_ptr_inc;
              if (word_ptr_inc == {16'h0000, count}) begin
                state      <= RUN;
                boot_ready <= 1'b0;
                core_reset <= 1'b0;
                boot_done  <= 1'b1;
              end
            end else begin
              word_buf[{byte_cnt, 3'b000} +: 8] <= boot_data;
            end
          end
        end
        RUN: begin
          boot_ready <= 1'b0;
          core_reset <= 1'b0;
          boot_done  <= 1'b1;
        end
        default: begin
          state      <= HDR0;
          boot_ready <= 1'b0;
          core_reset <= 1'b1;
          boot_done  <= 1'b0;
        end
      endcase
    end
  end

`else

  logic [1:0] rel_cnt;
  logic       unused_boot;

  assign boot_we     = 1'b0;
  assign boot_waddr  = {IW{1'b0}};
  assign boot_wdata  = 32'h0000_0000;
  assign boot_ready  = 1'b0;
  assign unused_boot = ^{boot_data, boot_valid};

  // Hold the core in reset for exactly two edges after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rel_cnt    <= 2'd0;
      core_reset <= 1'b1;
      boot_done  <= 1'b0;
    end else if (core_reset) begin
      if (rel_cnt == 2'd1) begin
        core_reset <= 1'b0;
        boot_done  <= 1'b1;
      end else begin
        rel_cnt <= rel_cnt + 2'd1;
      end
    end else begin
      rel_cnt <= rel_cnt;
    end
  end

`endif

endmodule

// File: tb/tb_boot_mem.sv
module tb_boot_mem;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic        mem_rd = 1'b0;
  logic        mem_wr = 1'b0;
  logic [31:0] mem_rdata;
  logic        addr_err;
  logic        core_reset;
  logic [7:0]  boot_data = 8'h00;
  logic        boot_valid = 1'b0;
  logic        boot_ready;
  logic        boot_done;

  always #5 clk = ~clk;

  boot_mem #(
    .ADDR_WIDTH (32),
    .DEPTH_WORDS(DEPTH),
    .INIT_FILE  ("")
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_rdata (mem_rdata),
    .addr_err  (addr_err),
    .core_reset(core_reset),
    .boot_data (boot_data),
    .boot_valid(boot_valid),
    .boot_ready(boot_ready),
    .boot_done (boot_done)
  );

  typedef struct {
    logic        err;
    logic        chk;
    logic [31:0] data;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          tests = 0;
  int          fails = 0;
  int          mon_tests = 0;
  int          mon_fails = 0;
  logic        strobe_seen = 1'b0;

  // reference model
  logic [31:0] model_mem [DEPTH];
  bit          known [DEPTH];
  logic [31:0] last_rdata = 32'h0;
  bit          last_known = 1'b1;
  bit          core_up = 1'b0;
  logic [7:0]  boot_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: pop expectation one cycle after every strobe
  always @(posedge clk) strobe_seen <= mem_rd | mem_wr;

  always @(negedge clk) begin
    if (strobe_seen) begin
      if (sb_q.size() == 0) begin
        mon_tests++;
        mon_fails++;
        $display("FAIL sb_underflow: got response, expected none at %0t", $time);
      end else begin
        mon_e = sb_q.pop_front();
        mon_tests++;
        if (addr_err !== mon_e.err) begin
          mon_fails++;
          $display("FAIL addr_err: got %b expected %b at %0t", addr_err, mon_e.err, $time);
        end
        if (mon_e.chk) begin
          mon_tests++;
          if (mem_rdata !== mon_e.data) begin
            mon_fails++;
            $display("FAIL mem_rdata: got %h expected %h at %0t", mem_rdata, mon_e.data, $time);
          end
        end
      end
    end else begin
      mon_tests++;
      if (addr_err !== 1'b0) begin
        mon_fails++;
        $display("FAIL addr_err_idle: got %b expected 0 at %0t", addr_err, $time);
      end
    end
  end

  // issue one core request at a negedge; expectation computed from the rules
  task automatic core_req(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wd);
    exp_t e;
    bit   ok;
    int   i;
    ok = (addr[1:0] == 2'b00) && (addr < 32'(DEPTH * 4));
    i  = int'(addr >> 2);
    if (!core_up) begin
      e.err = 1'b0;
    end else begin
      e.err = !ok;
      if (rd) begin
        if (ok) begin
          last_known = known[i];
          last_rdata = model_mem[i];
        end else begin
          last_known = 1'b1;
          last_rdata = 32'h0;
        end
      end
      if (wr && ok) begin
        model_mem[i] = wd;
        known[i]     = 1'b1;
      end
    end
    e.chk  = last_known;
    e.data = last_rdata;
    sb_q.push_back(e);
    mem_rd = rd; mem_wr = wr; mem_addr = addr; mem_wdata = wd;
    @(negedge clk);
    mem_rd = 1'b0; mem_wr = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 9))
      0: a = (32'($urandom_range(0, DEPTH - 1)) << 2) + 32'($urandom_range(1, 3));
      1: a = 32'(DEPTH * 4) + (32'($urandom_range(0, 15)) << 2);
      2: a = 32'h8000_0000 | (32'($urandom_range(0, DEPTH - 1)) << 2);
      default: a = 32'($urandom_range(0, 15)) << 2;
    endcase
    return a;
  endfunction

  task automatic random_ops(input int n);
    int op;
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        @(negedge clk);
      end else begin
        op = int'($urandom_range(0, 2));
        core_req(op != 1, op != 0, rand_addr(), $urandom);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; boot_valid = 1'b0;
    #1;
    chk("async_core_reset", {31'h0, core_reset}, 32'h1);
    chk("async_boot_ready", {31'h0, boot_ready}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_mem_rdata", mem_rdata, 32'h0);
    chk("rst_addr_err", {31'h0, addr_err}, 32'h0);
    chk("rst_core_reset", {31'h0, core_reset}, 32'h1);
    chk("rst_boot_ready", {31'h0, boot_ready}, 32'h0);
    chk("rst_boot_done", {31'h0, boot_done}, 32'h0);
    last_rdata = 32'h0; last_known = 1'b1; core_up = 1'b0;
    reset = 1'b1;
  endtask

  // model of the loader: words fully received so far, bounded by count
  task automatic model_boot(input int nsent);
    int cnt;
    int words;
    cnt   = int'(boot_q[0]) | (int'(boot_q[1]) << 8);
    words = (nsent - 2) / 4;
    if (words > cnt) words = cnt;
    for (int w = 0; w < words; w++) begin
      if (w < DEPTH) begin
        model_mem[w] = {boot_q[2+4*w+3], boot_q[2+4*w+2], boot_q[2+4*w+1], boot_q[2+4*w]};
        known[w]     = 1'b1;
      end
    end
  endtask

  // stream nsend bytes of boot_q; n_final is the byte expected to finish boot
  task automatic send_boot(input int nsend, input int n_final, input bit gaps);
    int w;
    for (int k = 0; k < nsend; k++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        boot_valid = 1'b0;
        @(negedge clk);
      end
      boot_valid = 1'b1;
      boot_data  = boot_q[k];
      w = 0;
      while (boot_ready !== 1'b1 && w < 10) begin
        @(negedge clk);
        w++;
      end
      chk("boot_ready_wait", {31'h0, boot_ready}, 32'h1);
      @(negedge clk);
      if (k == n_final) begin
        chk("final_core_reset", {31'h0, core_reset}, 32'h0);
        chk("final_boot_done", {31'h0, boot_done}, 32'h1);
        chk("final_boot_ready", {31'h0, boot_ready}, 32'h0);
      end else begin
        chk("load_core_reset", {31'h0, core_reset}, 32'h1);
        chk("load_boot_done", {31'h0, boot_done}, 32'h0);
      end
    end
    boot_valid = 1'b0;
  endtask

  task automatic post_reset();
`ifdef BOOT_MEM_BOOTLOAD_EN
    @(negedge clk);
    chk("ready_after_release", {31'h0, boot_ready}, 32'h1);
    chk("hold_core_reset", {31'h0, core_reset}, 32'h1);
`else
    boot_valid = 1'b1;
    @(negedge clk);
    chk("edge1_core_reset", {31'h0, core_reset}, 32'h1);
    chk("edge1_boot_done", {31'h0, boot_done}, 32'h0);
    @(negedge clk);
    chk("edge2_core_reset", {31'h0, core_reset}, 32'h0);
    chk("edge2_boot_done", {31'h0, boot_done}, 32'h1);
    chk("tied_boot_ready", {31'h0, boot_ready}, 32'h0);
    boot_valid = 1'b0;
    core_up = 1'b1;
`endif
  endtask

  task automatic directed_core();
    core_req(1'b0, 1'b1, 32'h8, 32'hDEAD_BEEF);
    core_req(1'b1, 1'b1, 32'h8, 32'h1234_5678);
    core_req(1'b1, 1'b0, 32'h8, 32'h0);
    core_req(1'b1, 1'b0, 32'h6, 32'h0);
    @(negedge clk);
    core_req(1'b0, 1'b1, 32'(DEPTH * 4), 32'hFFFF_FFFF);
    core_req(1'b1, 1'b0, 32'h0, 32'h0);
    core_req(1'b0, 1'b1, 32'h10, 32'hA5A5_5A5A);
    core_req(1'b1, 1'b0, 32'h10, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = 32'h0;
      known[i]     = 1'b0;
    end
    do_reset();
    post_reset();
`ifdef BOOT_MEM_BOOTLOAD_EN
    // requests while the core is held in reset are ignored
    core_req(1'b1, 1'b1, 32'h6, 32'h1111_1111);
    core_req(1'b1, 1'b0, 32'h0, 32'h0);
    // 2-word image
    boot_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    send_boot(10, 9, 1'b0);
    model_boot(10);
    core_up = 1'b1;
    chk("model_w0", model_mem[0], 32'h0000_0013);
    core_req(1'b1, 1'b0, 32'h0, 32'h0);
    core_req(1'b1, 1'b0, 32'h4, 32'h0);
    directed_core();
    random_ops(200);
    // reset after the 5th data byte of a 3-word image
    boot_q = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    do_reset();
    post_reset();
    send_boot(7, -1, 1'b0);
    model_boot(7);
    do_reset();
    post_reset();
    boot_q = '{8'h01, 8'h00, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
    send_boot(6, 5, 1'b0);
    model_boot(6);
    core_up = 1'b1;
    core_req(1'b1, 1'b0, 32'h0, 32'h0);
    core_req(1'b1, 1'b0, 32'h4, 32'h0);
    core_req(1'b1, 1'b0, 32'h8, 32'h0);
    // zero-count header, with an ignored write before it
    do_reset();
    post_reset();
    core_req(1'b0, 1'b1, 32'h0, 32'hFFFF_FFFF);
    boot_q = '{8'h00, 8'h00};
    send_boot(2, 1, 1'b0);
    core_up = 1'b1;
    boot_valid = 1'b1; boot_data = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("run_boot_ready", {31'h0, boot_ready}, 32'h0);
      chk("run_boot_done", {31'h0, boot_done}, 32'h1);
      chk("run_core_reset", {31'h0, core_reset}, 32'h0);
    end
    boot_valid = 1'b0;
    core_req(1'b1, 1'b0, 32'h0, 32'h0);
    random_ops(50);
    // image longer than the memory, with idle gaps on boot_valid
    do_reset();
    post_reset();
    boot_q = '{8'(DEPTH + 2), 8'h00};
    for (int k = 0; k < 4 * (DEPTH + 2); k++) boot_q.push_back(8'($urandom));
    send_boot(boot_q.size(), boot_q.size() - 1, 1'b1);
    model_boot(boot_q.size());
    core_up = 1'b1;
    core_req(1'b1, 1'b0, 32'h0, 32'h0);
    core_req(1'b1, 1'b0, 32'h4, 32'h0);
    core_req(1'b1, 1'b0, 32'((DEPTH - 1) * 4), 32'h0);
    random_ops(100);
`else
    core_req(1'b0, 1'b1, 32'h0, 32'h0000_0013);
    core_req(1'b1, 1'b0, 32'h0, 32'h0);
    directed_core();
    random_ops(200);
    do_reset();
    post_reset();
    core_req(1'b1, 1'b0, 32'h8, 32'h0);
    random_ops(100);
`endif
    @(negedge clk);
    @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'h0);
    tests = tests + mon_tests;
    fails = fails + mon_fails;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
